// File: rtl/fp16_square_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp16_square_seq_pkg
// Description : Shared FP16 constants and the squarer FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package fp16_square_seq_pkg;

    localparam logic [15:0] FP16_QNAN = 16'hFE00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    localparam int FP16_BIAS = 15;
    localparam int FP16_EMAX = 15;
    localparam int FP16_EMIN = -14;

    // Number of shift-add iterations, one per mantissa bit (hidden bit included)
    localparam int SQ_ITERS = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        PACK = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp16_square_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : fp16_square_seq_if
// Description : Request/result signals of the FP16 squarer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp16_square_seq_if;

    logic        start;
    logic [15:0] in_data;
    logic        busy;
    logic        result_valid;
    logic [15:0] out_data;

    // Requester side
    modport master (
        output start,
        output in_data,
        input  busy,
        input  result_valid,
        input  out_data
    );

    // Squarer side
    modport slave (
        input  start,
        input  in_data,
        output busy,
        output result_valid,
        output out_data
    );

endinterface
`default_nettype wire

// File: rtl/fp16_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : fp16_normalizer
// Description : Unbiased exponent and 11-bit mantissa with m[10]=1; subnormal
//               inputs are shifted up so the range of e becomes -24..15.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_normalizer
    import fp16_square_seq_pkg::*;
(
    input  logic [14:0]       x,
    input  logic              sub,
    output logic signed [6:0] e,
    output logic [10:0]       m
);

    logic [3:0] lead;

    // Leading-one search over the fraction; only meaningful for subnormals
    always_comb begin
        lead = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (x[i]) begin
                lead = 4'(i);
            end
        end
    end

    // Subnormal value is frac * 2^-24; moving the leading one to bit 10
    // leaves exponent lead - 24
    always_comb begin
        if (sub) begin
            m = 11'({1'b0, x[9:0]} << (4'd10 - lead));
            e = {3'b000, lead} - 7'd24;
        end else begin
            m = {1'b1, x[9:0]};
            e = {2'b00, x[14:10]} - 7'(FP16_BIAS);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_packer.sv
`default_nettype none
// ============================================================================
// Module      : fp16_packer
// Description : Packs sign, unbiased exponent and 11-bit mantissa into FP16.
//               Normal and subnormal ranges, truncating; does not saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_packer
    import fp16_square_seq_pkg::*;
(
    input  logic              sign,
    input  logic signed [7:0] exp,
    input  logic [10:0]       mant,
    output logic [15:0]       result
);

    localparam logic signed [7:0] EMIN8     = 8'(FP16_EMIN);
    localparam logic signed [7:0] SUB_FLOOR = -8'sd25;

    logic [7:0] shamt;

    // Normal range keeps the mantissa; subnormal range shifts it right by the
    // distance below EMIN; anything lower flushes to zero
    always_comb begin
        shamt  = 8'd0;
        result = FP16_ZERO;
        if (exp >= EMIN8) begin
            result = {sign, 5'(exp + 8'(FP16_BIAS)), mant[9:0]};
        end else if (exp >= SUB_FLOOR) begin
            shamt  = 8'(EMIN8 - exp);
            result = {sign, 5'd0, 10'(mant >> shamt)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_special_detector.sv
`default_nettype none
// ============================================================================
// Module      : fp16_special_detector
// Description : Classifies the magnitude of an FP16 value (NaN/inf/zero/sub).
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_special_detector (
    input  logic [14:0] x,
    output logic        nan,
    output logic        inf,
    output logic        zero,
    output logic        sub
);

    logic exp_ones;
    logic exp_zero;
    logic frac_zero;

    assign exp_ones  = (x[14:10] == 5'h1F);
    assign exp_zero  = (x[14:10] == 5'h00);
    assign frac_zero = (x[9:0] == 10'h000);

    assign nan  = exp_ones & ~frac_zero;
    assign inf  = exp_ones &  frac_zero;
    assign zero = exp_zero &  frac_zero;
    assign sub  = exp_zero & ~frac_zero;

endmodule
`default_nettype wire

// File: rtl/fp16_special_handler.sv
`default_nettype none
// ============================================================================
// Module      : fp16_special_handler
// Description : Fixed results for special-class operands (NaN > inf > zero).
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_special_handler
    import fp16_square_seq_pkg::*;
(
    input  logic        nan,
    input  logic        inf,
    input  logic        zero,
    output logic        special,
    output logic [15:0] value
);

    // Priority select of the canned result; special drops when none applies
    always_comb begin
        special = 1'b1;
        value   = FP16_ZERO;
        if (nan) begin
            value = FP16_QNAN;
        end else if (inf) begin
            value = FP16_PINF;
        end else if (zero) begin
            value = FP16_ZERO;
        end else begin
            special = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_square_mult_core.sv
`default_nettype none
// ============================================================================
// Module      : fp16_square_mult_core
// Description : Shift-add squarer for an 11-bit mantissa, one bit per step.
//               Exposes the top 12 product bits; lower bits are truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_square_mult_core
    import fp16_square_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [10:0] m_in,
    output logic        done,
    output logic [11:0] hi
);

    logic [10:0] m;
    logic [21:0] p;
    logic [3:0]  cnt;

    // The step that consumes the last mantissa bit is flagged as done
    assign done = (cnt == 4'(SQ_ITERS - 1));
    assign hi   = p[21:10];

    // Load clears the accumulator; each step adds m << i when m[i] is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m   <= 11'd0;
            p   <= 22'd0;
            cnt <= 4'd0;
        end else if (load) begin
            m   <= m_in;
            p   <= 22'd0;
            cnt <= 4'd0;
        end else if (step) begin
            if (m[cnt]) begin
                p <= p + ({11'd0, m} << cnt);
            end
            cnt <= cnt + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_square_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp16_square_seq
// Description : Sequential FP16 squarer, x*x, fixed 12-cycle latency.
//               IDLE -> MULT (11 cycles) -> PACK (1 cycle) -> IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_square_seq
    import fp16_square_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    fp16_square_seq_if.slave  bus
);

    localparam logic signed [7:0] EMAX8 = 8'(FP16_EMAX);

    state_t state;

    // Front-end decode of the live operand
    logic              nan_in, inf_in, zero_in, sub_in;
    logic signed [6:0] e_in;
    logic [10:0]       m_in;

    // Operand state captured on the accepting edge
    logic              sign_r;
    logic signed [6:0] e_r;
    logic              nan_r, inf_r, zero_r;

    // Registered outputs
    logic        busy_reg;
    logic        valid_reg;
    logic [15:0] out_reg;

    // Datapath
    logic              load, step, core_done;
    logic [11:0]       hi;
    logic              carry;
    logic [10:0]       mant;
    logic signed [7:0] exp_res;
    logic              special;
    logic [15:0]       special_value;
    logic [15:0]       packed_value;
    logic [15:0]       result;

    fp16_special_detector u_detector (
        .x    (bus.in_data[14:0]),
        .nan  (nan_in),
        .inf  (inf_in),
        .zero (zero_in),
        .sub  (sub_in)
    );

    fp16_normalizer u_normalizer (
        .x   (bus.in_data[14:0]),
        .sub (sub_in),
        .e   (e_in),
        .m   (m_in)
    );

    assign load = (state == IDLE) && bus.start;
    assign step = (state == MULT);

    fp16_square_mult_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .m_in  (m_in),
        .done  (core_done),
        .hi    (hi)
    );

    // m*m lies in [2^20, 2^22); a set top bit means one extra exponent step
    assign carry   = hi[11];
    assign mant    = carry ? hi[11:1] : hi[10:0];
    assign exp_res = $signed({e_r, 1'b0}) + $signed({7'd0, carry});

    fp16_special_handler u_handler (
        .nan     (nan_r),
        .inf     (inf_r),
        .zero    (zero_r),
        .special (special),
        .value   (special_value)
    );

    // Sign of x*x is s^s, i.e. always positive
    fp16_packer u_packer (
        .sign   (sign_r ^ sign_r),
        .exp    (exp_res),
        .mant   (mant),
        .result (packed_value)
    );

    // Result priority: special class, then overflow (packer would wrap), then packer
    always_comb begin
        result = packed_value;
        if (special) begin
            result = special_value;
        end else if (exp_res > EMAX8) begin
            result = FP16_PINF;
        end
    end

    // Control FSM with registered busy/result_valid/out_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            out_reg   <= FP16_ZERO;
            sign_r    <= 1'b0;
            e_r       <= 7'sd0;
            nan_r     <= 1'b0;
            inf_r     <= 1'b0;
            zero_r    <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= MULT;
                        busy_reg <= 1'b1;
                        sign_r   <= bus.in_data[15];
                        e_r      <= e_in;
                        nan_r    <= nan_in;
                        inf_r    <= inf_in;
                        zero_r   <= zero_in;
                    end
                end
                MULT: begin
                    if (core_done) begin
                        state <= PACK;
                    end
                end
                PACK: begin
                    out_reg   <= result;
                    valid_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_reg;
    assign bus.result_valid = valid_reg;
    assign bus.out_data     = out_reg;

endmodule
`default_nettype wire

// File: tb/tb_fp16_square_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_square_seq
// Description : Directed self-checking bench for the FP16 squarer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_square_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fp16_square_seq_if bus_if ();

    fp16_square_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs [16];

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Present one request; returns just after the accepting edge
    task automatic issue(input logic [15:0] d);
        bus_if.start   = 1'b1;
        bus_if.in_data = d;
        @(posedge clk);
        #1;
        bus_if.start   = 1'b0;
    endtask

    // Wait for result_valid, bounded; lat=0 means it never came
    task automatic wait_result(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.result_valid) begin
                lat = k;
                if (bus_if.busy) busy_ok = 1'b0;
                break;
            end
            if (!bus_if.busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int  lat;
        bit  bok;
        bit  flag;

        vecs[0]  = '{16'h3E00, 16'h4080};  // 1.5^2 = 2.25
        vecs[1]  = '{16'hC000, 16'h4400};  // (-2)^2 = 4
        vecs[2]  = '{16'h3C00, 16'h3C00};  // 1
        vecs[3]  = '{16'h5C00, 16'h7C00};  // 256^2 overflow
        vecs[4]  = '{16'h7BFF, 16'h7C00};  // max normal overflow
        vecs[5]  = '{16'h2000, 16'h0400};  // 2^-14, smallest normal
        vecs[6]  = '{16'h1C00, 16'h0100};  // 2^-16 subnormal
        vecs[7]  = '{16'h0001, 16'h0000};  // underflow to zero
        vecs[8]  = '{16'h8000, 16'h0000};  // -0
        vecs[9]  = '{16'h7E01, 16'hFE00};  // NaN
        vecs[10] = '{16'hFC01, 16'hFE00};  // negative NaN
        vecs[11] = '{16'hFC00, 16'h7C00};  // -inf
        vecs[12] = '{16'h3800, 16'h3400};  // 0.25
        vecs[13] = '{16'h3FFF, 16'h43FE};  // truncated product
        vecs[14] = '{16'h1A00, 16'h0090};  // 1.125*2^-17 subnormal
        vecs[15] = '{16'h0200, 16'h0000};  // subnormal input, 2^-30

        bus_if.start   = 1'b0;
        bus_if.in_data = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  {31'd0, bus_if.busy},         32'd0);
        check("reset_valid", {31'd0, bus_if.result_valid}, 32'd0);
        check("reset_data",  {16'd0, bus_if.out_data},     32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single operations
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].din);
            check($sformatf("busy_after_accept[%0d]", i), {31'd0, bus_if.busy}, 32'd1);
            wait_result(lat, bok);
            check($sformatf("latency[%0d]", i), lat, 32'd12);
            check($sformatf("busy_window[%0d]", i), {31'd0, bok}, 32'd1);
            check($sformatf("data[%0h]", vecs[i].din), {16'd0, bus_if.out_data}, {16'd0, vecs[i].dout});
            @(posedge clk);
            #1;
            check($sformatf("valid_pulse[%0d]", i), {31'd0, bus_if.result_valid}, 32'd0);
            check($sformatf("data_hold[%0d]", i), {16'd0, bus_if.out_data}, {16'd0, vecs[i].dout});
        end

        // start while busy is ignored
        issue(16'h3E00);
        flag = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3 || k == 7) begin
                bus_if.start   = 1'b1;
                bus_if.in_data = 16'h7E01;
            end else begin
                bus_if.start   = 1'b0;
            end
            @(posedge clk);
            #1;
            if (k < 12 && bus_if.result_valid) flag = 1'b1;
        end
        bus_if.start = 1'b0;
        check("busy_start_early_valid", {31'd0, flag}, 32'd0);
        check("busy_start_valid", {31'd0, bus_if.result_valid}, 32'd1);
        check("busy_start_data", {16'd0, bus_if.out_data}, 32'h4080);
        flag = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.result_valid || bus_if.busy) flag = 1'b1;
        end
        check("busy_start_no_extra", {31'd0, flag}, 32'd0);

        // Back-to-back: new start on the result_valid cycle
        issue(16'h3C00);
        wait_result(lat, bok);
        check("b2b_first_lat", lat, 32'd12);
        check("b2b_first_data", {16'd0, bus_if.out_data}, 32'h3C00);
        issue(16'hC000);
        check("b2b_second_busy", {31'd0, bus_if.busy}, 32'd1);
        check("b2b_hold_data", {16'd0, bus_if.out_data}, 32'h3C00);
        wait_result(lat, bok);
        check("b2b_second_lat", lat, 32'd12);
        check("b2b_second_data", {16'd0, bus_if.out_data}, 32'h4400);
        @(posedge clk);
        #1;

        // Reset in the middle of an operation
        issue(16'h3E00);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_busy",  {31'd0, bus_if.busy},         32'd0);
        check("midreset_valid", {31'd0, bus_if.result_valid}, 32'd0);
        check("midreset_data",  {16'd0, bus_if.out_data},     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus_if.result_valid || bus_if.busy) flag = 1'b1;
        end
        check("midreset_no_result", {31'd0, flag}, 32'd0);

        // Operation after recovery
        issue(16'h2000);
        wait_result(lat, bok);
        check("post_reset_lat", lat, 32'd12);
        check("post_reset_data", {16'd0, bus_if.out_data}, 32'h0400);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp16_square_seq.md
# fp16_square_seq

Sequential IEEE-754 half-precision squarer: computes x·x for one FP16 operand with a multi-cycle shift-add mantissa multiplier. It is the inverse operation to the FP16 square-root unit and shares that unit's front-end and back-end:

- front-end: `fp16_special_detector`, `fp16_special_handler`, `fp16_normalizer`;
- back-end: `fp16_packer`.

This keeps special-value, subnormal and truncation behaviour consistent across the arithmetic datapath.

## Interface
- No parameters. Width is fixed at FP16.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only while idle
- in_data  in  16  FP16 operand; sampled on the accepting edge only
- busy  out  1  high from the accepting edge until the result edge
- result_valid  out  1  one-cycle pulse; out_data is valid while this is high
- out_data  out  16  FP16 result; holds its value until the next result

## Operation
- **Accept.** In IDLE, start=1 causes the following on the next edge:
  - decode and normalize in_data;
  - register sign (discarded), the 7-bit signed unbiased exponent e, the 11-bit mantissa m (hidden bit included) and the class flags (nan, inf, zero);
  - clear the 22-bit accumulator P and set the 4-bit iteration counter to 0.
- **Subnormal input.** The input is normalized so that m[10]=1, with e ranging from -24 to 15.
- **MULT state, 11 cycles.** On iteration i (i = 0..10): if m[i]=1, P ← P + (m << i). The counter increments each cycle; after i = 10 the block enters PACK.
- **Exponent and mantissa.** Result exponent E = 2e, in 8-bit signed arithmetic.
  - If P[21]=1: mant = P[21:11] and E = E+1.
  - Otherwise: mant = P[20:10].
  - Lower product bits are truncated (round toward zero), matching the packer.
- **PACK state, 1 cycle.** Select the result in this priority order:
  1. Input NaN, either sign → 16'hFE00.
  2. Input ±inf → 16'h7C00.
  3. Input ±0 → 16'h0000.
  4. E > 15 → 16'h7C00 (overflow). The packer is not used here because it does not saturate.
  5. -14 ≤ E ≤ 15 → normal result, sign 0.
  6. -25 ≤ E < -14 → packer subnormal path: mant >> (-14 - E), truncated.
  7. E < -25 → 16'h0000.
- **Sign.** The result sign is always 0.
- **start while busy.** Ignored; it is neither queued nor allowed to corrupt the state.
- **start on the result_valid cycle.** The FSM is already in IDLE, so the request is accepted.

## Timing
- FSM states: IDLE → MULT (11 cycles) → PACK (1 cycle) → IDLE.
- Fixed latency. With start accepted at edge N:
  - out_data is updated and result_valid rises at edge N+12;
  - result_valid is cleared at edge N+13.
- Special values take the same 12-cycle path; there is no early exit.
- Reset values: busy=0, result_valid=0, out_data=16'h0000, state=IDLE, P=0, counter=0.
- Reset asserted mid-operation: the operation is abandoned immediately, no result_valid is produced, and the block is idle on the first edge after release.
- Maximum throughput: one result every 12 cycles.

## Structure
- Shared package contents:
  - FP16_QNAN = 16'hFE00, FP16_PINF = 16'h7C00, FP16_ZERO = 16'h0000;
  - FP16_BIAS = 15, FP16_EMAX = 15, FP16_EMIN = -14;
  - SQ_ITERS = 11;
  - state enum {IDLE, MULT, PACK}.
- Sub-module `fp16_square_mult_core` holds the registers m, P and the counter. Its ports are load and step, plus a done flag. The top level contains the FSM, the exponent/overflow logic and the instantiated packer.
- The existing detector, handler, normalizer and packer are instantiated as-is.

## Test plan
- 0x3E00 (1.5), start at edge N → out_data = 0x4080 (2.25), result_valid pulses only in the cycle after edge N+12; busy is high for cycles N+1..N+12.
- 0xC000 (-2.0) → 0x4400 (4.0, positive sign); 0x3C00 (1.0) → 0x3C00.
- 0x5C00 (256) → 0x7C00 (overflow); 0x7BFF → 0x7C00.
- Underflow boundaries:
  - 0x2000 (2^-7) → 0x0400;
  - 0x1C00 (2^-8) → 0x0100 (subnormal);
  - 0x0001 → 0x0000;
  - 0x8000 → 0x0000.
- Special values:
  - 0x7E01 → 0xFE00;
  - 0xFC01 → 0xFE00;
  - 0xFC00 → 0x7C00.
- Control:
  - start pulsed at cycles N+3 and N+7 while busy → ignored; the single result is correct;
  - back-to-back start on the result_valid cycle → second result arrives 12 cycles later;
  - rst_n low at N+5 → no result_valid, outputs return to reset values.
